// File: rtl/lane_scorekeeper.sv
// Reads the lane symbol at the player cell on each tick, scores dodges in BCD, flags collisions, keeps a best score.
// Latency: tick at edge N updates state/score/game_over at N+1 and the score digits at N+2.
module lane_scorekeeper #(
  parameter logic [6:0] SYM_UP        = 7'h1C,
  parameter logic [6:0] SYM_DOWN      = 7'h23,
  parameter logic [6:0] SYM_EMPTY     = 7'h7F,
  parameter int         SCORE_MAX     = 999,
  parameter bit         BLANK_LEADING = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        start,
  input  logic        player_up,
  input  logic [6:0]  lane_seg,
  output logic        playing,
  output logic        game_over,
  output logic        sym_err,
  output logic [11:0] score_bcd,
  output logic [11:0] best_bcd,
  output logic [6:0]  score_seg2,
  output logic [6:0]  score_seg1,
  output logic [6:0]  score_seg0
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [11:0] MAX_BCD = {4'(SCORE_MAX / 100), 4'((SCORE_MAX / 10) % 10), 4'(SCORE_MAX % 10)};
  localparam logic [6:0]  SEG_ZERO = 7'h40;

  state_t state;
  logic   start_q;
  logic   start_rise;
  logic   is_up;
  logic   is_down;
  logic   is_empty;
  logic   hit;
  logic   dodge;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    d2 = v[11:8];
    d1 = v[7:4];
    d0 = v[3:0];
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    return {d2, d1, d0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SYM_EMPTY;
    endcase
    return s;
  endfunction

  assign start_rise = start & ~start_q;

  always_comb begin
    is_up    = (lane_seg == SYM_UP);
    is_down  = (lane_seg == SYM_DOWN);
    is_empty = (lane_seg == SYM_EMPTY);
    hit      = (is_up & player_up) | (is_down & ~player_up);
    dodge    = (is_up & ~player_up) | (is_down & player_up);
  end

  // start_q resets high so a start already asserted at reset release is not an edge.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      start_q   <= 1'b1;
      playing   <= 1'b0;
      game_over <= 1'b0;
      sym_err   <= 1'b0;
      score_bcd <= 12'h000;
      best_bcd  <= 12'h000;
    end else begin
      start_q   <= start;
      game_over <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_rise) begin
            state     <= RUN;
            playing   <= 1'b1;
            score_bcd <= 12'h000;
            sym_err   <= 1'b0;
          end
        end
        RUN: begin
          if (tick) begin
            if (hit) begin
              state     <= OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
              if (score_bcd > best_bcd) best_bcd <= score_bcd;
            end else if (dodge) begin
              if (score_bcd != MAX_BCD) score_bcd <= bcd_inc(score_bcd);
            end else if (!is_empty) begin
              sym_err <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
        end
      endcase
    end
  end

  // Digits are a registered view of score_bcd, one cycle behind it.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      score_seg2 <= BLANK_LEADING ? SYM_EMPTY : SEG_ZERO;
      score_seg1 <= BLANK_LEADING ? SYM_EMPTY : SEG_ZERO;
      score_seg0 <= SEG_ZERO;
    end else begin
      score_seg0 <= seg7(score_bcd[3:0]);
      score_seg1 <= (BLANK_LEADING && score_bcd[11:4] == 8'h00) ? SYM_EMPTY : seg7(score_bcd[7:4]);
      score_seg2 <= (BLANK_LEADING && score_bcd[11:8] == 4'h0) ? SYM_EMPTY : seg7(score_bcd[11:8]);
    end
  end

endmodule

// File: tb/tb_lane_scorekeeper.sv
// Directed bench for lane_scorekeeper: inputs driven and outputs sampled on the falling edge.
module tb_lane_scorekeeper;

  logic        CLOCK_50;
  logic        reset_n;
  logic        tick;
  logic        start;
  logic        player_up;
  logic [6:0]  lane_seg;
  logic        playing;
  logic        game_over;
  logic        sym_err;
  logic [11:0] score_bcd;
  logic [11:0] best_bcd;
  logic [6:0]  score_seg2;
  logic [6:0]  score_seg1;
  logic [6:0]  score_seg0;

  int errors = 0;
  int checks = 0;

  lane_scorekeeper dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .tick       (tick),
    .start      (start),
    .player_up  (player_up),
    .lane_seg   (lane_seg),
    .playing    (playing),
    .game_over  (game_over),
    .sym_err    (sym_err),
    .score_bcd  (score_bcd),
    .best_bcd   (best_bcd),
    .score_seg2 (score_seg2),
    .score_seg1 (score_seg1),
    .score_seg0 (score_seg0)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One tick with the given symbol; returns on the falling edge after the sampling edge.
  task automatic do_tick(input logic [6:0] sym, input logic up);
    @(negedge CLOCK_50);
    tick = 1'b1; lane_seg = sym; player_up = up;
    @(negedge CLOCK_50);
    tick = 1'b0; lane_seg = 7'h00;
  endtask

  task automatic start_pulse(input logic with_tick);
    @(negedge CLOCK_50);
    start = 1'b1; tick = with_tick; lane_seg = 7'h1C; player_up = 1'b0;
    @(negedge CLOCK_50);
    start = 1'b0; tick = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_playing"}, 32'(playing), 32'h0);
    chk({tag, "_game_over"}, 32'(game_over), 32'h0);
    chk({tag, "_sym_err"}, 32'(sym_err), 32'h0);
    chk({tag, "_score"}, 32'(score_bcd), 32'h000);
    chk({tag, "_best"}, 32'(best_bcd), 32'h000);
    chk({tag, "_seg2"}, 32'(score_seg2), 32'h7F);
    chk({tag, "_seg1"}, 32'(score_seg1), 32'h7F);
    chk({tag, "_seg0"}, 32'(score_seg0), 32'h40);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b1; tick = 1'b0; player_up = 1'b0; lane_seg = 7'h00;
    repeat (3) @(negedge CLOCK_50);
    chk_reset_vals("rst");

    // Start held high across reset release must not start a game.
    reset_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("held_start_idle", 32'(playing), 32'h0);
    start = 1'b0;
    start_pulse(1'b0);
    chk("start_playing", 32'(playing), 32'h1);
    chk("start_score", 32'(score_bcd), 32'h000);

    do_tick(7'h1C, 1'b0);
    do_tick(7'h7F, 1'b0);
    do_tick(7'h1C, 1'b0);
    chk("two_dodges", 32'(score_bcd), 32'h002);
    @(negedge CLOCK_50);
    chk("two_seg0", 32'(score_seg0), 32'h24);
    chk("two_seg1", 32'(score_seg1), 32'h7F);
    chk("two_seg2", 32'(score_seg2), 32'h7F);

    do_tick(7'h1C, 1'b1);
    chk("hit_game_over", 32'(game_over), 32'h1);
    chk("hit_playing", 32'(playing), 32'h0);
    chk("hit_best", 32'(best_bcd), 32'h002);
    chk("hit_score", 32'(score_bcd), 32'h002);
    @(negedge CLOCK_50);
    chk("game_over_one_cycle", 32'(game_over), 32'h0);
    do_tick(7'h23, 1'b1);
    do_tick(7'h23, 1'b1);
    chk("over_score_held", 32'(score_bcd), 32'h002);
    chk("over_still_idle", 32'(playing), 32'h0);

    // Start and tick together: the start wins and the dodge is dropped.
    start_pulse(1'b1);
    chk("restart_playing", 32'(playing), 32'h1);
    chk("restart_score", 32'(score_bcd), 32'h000);
    chk("restart_best", 32'(best_bcd), 32'h002);

    repeat (9) do_tick(7'h1C, 1'b0);
    chk("nine", 32'(score_bcd), 32'h009);
    do_tick(7'h23, 1'b1);
    chk("carry_ten", 32'(score_bcd), 32'h010);
    @(negedge CLOCK_50);
    chk("ten_seg2", 32'(score_seg2), 32'h7F);
    chk("ten_seg1", 32'(score_seg1), 32'h79);
    chk("ten_seg0", 32'(score_seg0), 32'h40);

    do_tick(7'h55, 1'b0);
    chk("bad_sym_err", 32'(sym_err), 32'h1);
    chk("bad_sym_score", 32'(score_bcd), 32'h010);
    chk("bad_sym_run", 32'(playing), 32'h1);

    repeat (90) do_tick(7'h1C, 1'b0);
    chk("hundred", 32'(score_bcd), 32'h100);
    @(negedge CLOCK_50);
    chk("hundred_seg2", 32'(score_seg2), 32'h79);
    chk("hundred_seg1", 32'(score_seg1), 32'h40);
    chk("hundred_seg0", 32'(score_seg0), 32'h40);
    chk("sym_err_sticky", 32'(sym_err), 32'h1);

    repeat (899) do_tick(7'h23, 1'b1);
    chk("max_score", 32'(score_bcd), 32'h999);
    repeat (2) do_tick(7'h1C, 1'b0);
    chk("saturate", 32'(score_bcd), 32'h999);
    @(negedge CLOCK_50);
    chk("max_seg2", 32'(score_seg2), 32'h10);
    chk("max_seg1", 32'(score_seg1), 32'h10);
    chk("max_seg0", 32'(score_seg0), 32'h10);

    do_tick(7'h23, 1'b0);
    chk("hit2_game_over", 32'(game_over), 32'h1);
    chk("hit2_best", 32'(best_bcd), 32'h999);
    start_pulse(1'b0);
    chk("restart2_sym_err", 32'(sym_err), 32'h0);
    chk("restart2_best", 32'(best_bcd), 32'h999);
    chk("restart2_score", 32'(score_bcd), 32'h000);

    do_tick(7'h1C, 1'b0);
    do_tick(7'h55, 1'b0);
    chk("pre_reset_score", 32'(score_bcd), 32'h001);
    chk("pre_reset_sym_err", 32'(sym_err), 32'h1);
    // Asynchronous reset between edges: outputs must clear without a clock edge.
    @(posedge CLOCK_50);
    #3 reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    chk("post_reset_idle", 32'(playing), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_scorekeeper.md
Name: lane_scorekeeper

Overview:
- Sits at the player end of the scrolling obstacle lane and reads the 7-segment symbol stream that the obstacle spawner writes.
- On each game step it decodes the symbol arriving at the player cell and checks it against the player position.
- It scores dodged obstacles in BCD, detects collisions, and keeps a best score.
- It drives three active-low 7-segment score digits.
- It is the reader/decoder for the lane's symbol encoding and runs entirely in the CLOCK_50 domain, with tick used as a clock enable.

Parameters:
SYM_UP, 7'h1C, active-low pattern for an upper obstacle
SYM_DOWN, 7'h23, active-low pattern for a lower obstacle
SYM_EMPTY, 7'h7F, blank cell pattern
SCORE_MAX, 999, saturation value for the score (decimal, at most 999)
BLANK_LEADING, 1, when 1 leading zero digits display SYM_EMPTY

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle game-step strobe, synchronous to CLOCK_50
start  in  1  synchronized level, active-high; only its rising edge is used
player_up  in  1  1 = player in the upper cell, 0 = player in the lower cell
lane_seg  in  7  symbol entering the player cell, before the player overlay
playing  out  1  high while in RUN
game_over  out  1  one-cycle pulse on collision
sym_err  out  1  sticky flag: an undecodable symbol was sampled
score_bcd  out  12  current score, 3 BCD digits
best_bcd  out  12  highest completed-game score
score_seg2, score_seg1, score_seg0  out  7 each  active-low digits, hundreds/tens/units

Behaviour:
- One clock domain. All state is reset asynchronously when reset_n=0.
- Reset values:
  - state=IDLE, playing=0, game_over=0, sym_err=0, score_bcd=0, best_bcd=0.
  - start_q=1, so a start held high through reset release does not start a game.
  - score_seg2/1 = 7'h7F if BLANK_LEADING else 7'h40; score_seg0 = 7'h40.
- Start edge: start_rise = start & ~start_q; start_q is registered every cycle.
- States:
  - IDLE: tick ignored. start_rise -> RUN, clear score_bcd and sym_err.
  - RUN: playing=1. start ignored. On tick, decode lane_seg:
    - SYM_UP with player_up=1, or SYM_DOWN with player_up=0: collision -> OVER; game_over=1 for exactly the next cycle; score unchanged; best_bcd <= max(best_bcd, score_bcd) on the same edge.
    - SYM_UP with player_up=0, or SYM_DOWN with player_up=1: dodge; score_bcd += 1 in BCD, with units and tens carrying 9->0.
    - Saturation: at SCORE_MAX the score holds.
    - SYM_EMPTY: no action.
    - Any other value: sym_err<=1 (sticky until the next start_rise); the cell is treated as empty.
  - OVER: score and best held; tick ignored. start_rise -> RUN, clear score_bcd and sym_err; best_bcd is retained.
- Simultaneous events:
  - tick and start_rise in the same cycle in IDLE/OVER: start wins, tick is dropped.
  - In RUN, start_rise is ignored.
- Latency:
  - tick at edge N -> score_bcd / game_over / state updated at edge N+1.
  - score_seg* are registered from score_bcd and update at edge N+2.
- Digit encoding, active-low gfedcba: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10.
- Leading-zero blanking (BLANK_LEADING=1):
  - hundreds blank when 0;
  - tens blank when hundreds=0 and tens=0;
  - units are never blank.
- Decode uses lane_seg as sampled on the tick cycle only. lane_seg is don't-care when tick=0.
- Reset asserted mid-game: immediate return to reset values. best_bcd is lost.

Test Plan:
- Reset with start=1, release reset, hold start high -> remains IDLE, playing=0. Drop start, raise start -> playing=1 one cycle after the edge, score_bcd=0.
- In RUN, player_up=0, ticks with lane_seg=1C, 7F, 1C -> score_bcd=0x002 and score_seg0=7'h24 two cycles after the last tick; seg2/seg1=7F.
- In RUN, player_up=1, tick with lane_seg=1C -> game_over high for exactly one cycle, playing=0, best_bcd=score. Further ticks with 23 -> score unchanged.
- Preload 9 dodges, then a tick with 23 and player_up=1 -> score_bcd=0x010, seg1=7'h79, seg0=7'h40. Run to 999 -> further dodges keep 0x999.
- tick with lane_seg=7'h55 -> sym_err=1, score unchanged, still RUN. The next start_rise after OVER clears sym_err while best_bcd is retained.
- Assert reset_n=0 mid-RUN, asynchronously between edges -> all outputs return to reset values without a clock edge.
